// File: rtl/mem_pkg.sv
// Shared constants and types for the data-memory request controller.
package mem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int NUM_LANES   = 4;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half out of a bus word and sign/zero-extends it.
module lsu_load_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] rdata
);
  logic [NUM_LANES-1:0][7:0] lanes;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    lanes = word;
    b     = lanes[addr_lo];
    h     = addr_lo[1] ? word[31:16] : word[15:0];
    rdata = word;
    case (funct3)
      F3_B:    rdata = {{24{b[7]}}, b};
      F3_H:    rdata = {{16{h[15]}}, h};
      F3_BU:   rdata = {24'b0, b};
      F3_HU:   rdata = {16'b0, h};
      default: rdata = word;
    endcase
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory responder: validates core requests, runs one req/ack bus cycle
// per access while stalling the core, and returns extended load data.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              misaligned,
  output logic              access_fault,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic              bus_err,
  input  logic [31:0]       bus_rdata
);
  state_t state, state_nxt;
  logic [7:0] cnt;
  logic [2:0] f3_q;
  logic [1:0] alo_q;
  logic [31:0] ld_ext;
  logic [NUM_LANES-1:0]      be_c;
  logic [NUM_LANES-1:0][7:0] wd_c;
  logic req, both, f3_ok, misal, in_idle;
  logic accept, rej_fault, rej_misal;
  logic to_hit, wait_done, wait_fault, stall_c;

  // Lane enables and replicated store data, one slice per byte lane
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    localparam logic [1:0] LN = 2'(l);
    assign be_c[l] = (funct3[1:0] == 2'b00) ? (addr[1:0] == LN) :
                     (funct3[1:0] == 2'b01) ? (addr[1] == LN[1]) : 1'b1;
    assign wd_c[l] = (funct3[1:0] == 2'b00) ? wdata[7:0] :
                     (funct3[1:0] == 2'b01) ? wdata[8*(l%2) +: 8] : wdata[8*l +: 8];
  end

  always_comb begin
    req     = mem_read | mem_write;
    both    = mem_read & mem_write;
    in_idle = (state == IDLE);
    f3_ok   = mem_write ? (funct3 inside {F3_B, F3_H, F3_W})
                        : (funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misal   = ((funct3 == F3_H || funct3 == F3_HU) && addr[0]) ||
              (funct3 == F3_W && addr[1:0] != 2'b00);
    rej_fault = in_idle && req && (both || !f3_ok);
    rej_misal = in_idle && req && !both && f3_ok && misal;
    accept    = in_idle && req && !both && f3_ok && !misal;
    // err beats ack; timeout only when neither arrived on the last allowed cycle
    to_hit     = (cnt == 8'(TIMEOUT));
    wait_done  = bus_err | bus_ack | to_hit;
    wait_fault = (state == WAIT) && (bus_err || (!bus_ack && to_hit));
  end

  always_comb begin
    state_nxt = state;
    stall_c   = 1'b0;
    case (state)
      IDLE: if (accept) begin
        state_nxt = WAIT;
        stall_c   = 1'b1;
      end
      WAIT: begin
        stall_c = 1'b1;
        if (wait_done) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gate with reset so a request held during reset never stalls the core
  assign stall = reset_n & stall_c;

  lsu_load_align u_align (
    .funct3  (f3_q),
    .addr_lo (alo_q),
    .word    (bus_rdata),
    .rdata   (ld_ext)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      rdata        <= '0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_be       <= '0;
      bus_wdata    <= '0;
      misaligned   <= 1'b0;
      access_fault <= 1'b0;
      f3_q         <= '0;
      alo_q        <= '0;
    end else begin
      state        <= state_nxt;
      misaligned   <= rej_misal;
      access_fault <= rej_fault | wait_fault;
      if (accept) begin
        bus_req   <= 1'b1;
        bus_we    <= mem_write;
        bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
        bus_be    <= be_c;
        bus_wdata <= wd_c;
        f3_q      <= funct3;
        alo_q     <= addr[1:0];
        cnt       <= 8'd1;
      end else if (state == WAIT) begin
        if (wait_done) begin
          bus_req <= 1'b0;
          cnt     <= '0;
        end else begin
          cnt <= cnt + 8'd1;
        end
        if (wait_fault)                rdata <= '0;
        else if (bus_ack && !bus_we)   rdata <= ld_ext;
      end
    end
  end
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Responder side of the core's data-memory request interface.
- Accepts the per-instruction mem_read/mem_write strobes plus funct3/address/store data from the single-cycle datapath.
- Runs a req/ack transaction on the external data bus, holds the core's PC via stall while waiting, and returns aligned, sign/zero-extended load data.
- Detects misaligned, illegal-width and bus-fault conditions.

Parameters:
- ADDR_W, 32, byte-address width of core and bus.
- TIMEOUT, 255, max WAIT cycles without ack/err before the access is aborted as a fault (8-bit counter; legal 1..255).

Ports:
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- mem_read  in  1  load request from control decode
- mem_write  in  1  store request from control decode
- funct3  in  3  access width/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- addr  in  ADDR_W  byte address (ALU result)
- wdata  in  32  store data (rs2)
- rdata  out  32  extended load data, valid in RESP
- stall  out  1  hold PC/pipeline while high
- misaligned  out  1  one-cycle pulse: misaligned access rejected
- access_fault  out  1  one-cycle pulse: illegal request, bus error or timeout
- bus_req  out  1  bus request, held until ack/err/timeout
- bus_we  out  1  1 = write
- bus_addr  out  ADDR_W  word-aligned address (addr[1:0] forced 00)
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  transfer complete
- bus_err  in  1  transfer error
- bus_rdata  in  32  read word, valid with bus_ack

Behaviour:
- Clock clk; reset reset_n, asynchronous, active-low. Reset: state IDLE, timeout counter 0, rdata 0, bus_req/bus_we/bus_be/bus_addr/bus_wdata 0, misaligned 0, access_fault 0. stall is 0 in reset.
- Reset asserted mid-transaction drops bus_req immediately. The transaction is abandoned with no fault pulse.
- Request valid: req = mem_read | mem_write, sampled in IDLE only.

Request rejection in IDLE (no bus cycle; state stays IDLE; stall 0; flag pulses the following cycle):
- Both strobes high -> access_fault.
- Illegal funct3: loads 011/110/111; stores any except 000/001/010 -> access_fault.
- Misaligned: H/HU with addr[0]=1, W with addr[1:0]!=00 -> misaligned.

States:
- IDLE: on a valid, aligned request, stall=1 combinationally in the same cycle. Latch we, word address, be, wdata and funct3/addr[1:0]; go WAIT with bus_req=1 next cycle.
- WAIT: stall=1; bus_req and all bus_* outputs stable; counter increments per cycle.
  - bus_ack: capture extended bus_rdata (loads) -> RESP.
  - bus_err: access_fault pulse -> RESP; rdata 0.
  - Counter == TIMEOUT with no ack/err: access_fault pulse, bus_req drops -> RESP.
  - ack and err in the same cycle: err wins.
- RESP: bus_req=0, stall=0, rdata valid for this cycle (core writes back and advances PC). New requests are ignored this cycle; always -> IDLE.

Latency and bus signalling:
- Ack in the first WAIT cycle gives a 3-cycle access: IDLE, WAIT, RESP. Each extra wait state adds one cycle.
- A store's rdata remains the previous value.

Byte lanes:
- B/BU: be = 0001 << addr[1:0]; bus_wdata = {4{wdata[7:0]}}.
- H/HU: be = 0011 << {addr[1],1'b0}; bus_wdata = {2{wdata[15:0]}}.
- W: be = 1111; bus_wdata = wdata.

Load extraction:
- Select byte/half by latched addr[1:0].
- 000/001 sign-extend; 100/101 zero-extend; 010 passthrough.

Decomposition:
- Shared package mem_pkg:
  - funct3 width constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - enum state_t {IDLE, WAIT, RESP}.
  - TIMEOUT default.
- One combinational sub-module, lsu_load_align: inputs funct3, addr_lo[1:0], bus word; output extended 32-bit rdata. It is reused by the store-lane generator's checker in the bench.

Test Plan:
1. LW addr 0x100, ack after 2 wait cycles, bus_rdata 0xDEADBEEF -> stall high 4 cycles; bus_be 1111, bus_addr 0x100; rdata 0xDEADBEEF in RESP; stall 0.
2. LB addr 0x203, bus_rdata 0x80FF_0000 -> be 1000, rdata 0xFFFFFF80. LBU same -> rdata 0x00000080.
3. SH addr 0x0102, wdata 0x1234ABCD -> bus_we 1, bus_addr 0x100, be 1100, bus_wdata 0xABCDABCD; no rdata change.
4. LW addr 0x101 -> no bus_req, stall 0, misaligned pulse one cycle. mem_read & mem_write together -> access_fault pulse, no bus_req.
5. Load with no ack, TIMEOUT=4 -> bus_req high 4 WAIT cycles, access_fault pulse, stall released in RESP. bus_ack and bus_err same cycle -> access_fault.
6. reset_n low in 2nd WAIT cycle -> bus_req, stall and flags all 0 immediately; after release, state IDLE and next LW completes normally.
